fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the combinational control decoder.
- Holds the PC and fetches 16-bit instructions over a req/ack instruction-memory handshake.
- Latches each instruction in an instruction register and drives its decoded fields (opcode, func, register fields, immediates) to control and datapath.
- Computes the next PC from the decoder's nia return signal: nia=1 means sequential, nia=0 means jump.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/fetch_unit_pc_next_calc.sv | 26 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcodes, field positions and
// fetch FSM encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;
  localparam logic [3:0] OP_BR    = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_HALT  = 4'b1110;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RS_MSB   = 11;
  localparam int RS_LSB   = 9;
  localparam int RT_MSB   = 8;
  localparam int RT_LSB   = 6;
  localparam int RD_MSB   = 5;
  localparam int RD_LSB   = 3;
  localparam int FUNC_MSB = 2;
  localparam int FUNC_LSB = 0;
  localparam int IMM6_MSB = 5;
  localparam int JOFF_MSB = 11;

  typedef enum logic [1:0] {
    FS_REQ   = 2'd0,
    FS_ISSUE = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC computation: sequential PC+2, or PC+2 plus a signed word offset when
// nia is a definite 0 (an unknown nia falls through to sequential).
module pc_next_calc #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              nia,
  input  logic [11:0]       jump_off,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] off_ext;

  assign seq_pc  = pc + ADDR_W'(2);
  // Word offset becomes a byte offset, sign-extended to the PC width.
  assign off_ext = ADDR_W'($signed({jump_off, 1'b0}));

  always_comb begin
    next_pc = seq_pc;
    if (nia == 1'b0) begin
      next_pc = seq_pc + off_ext;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack fetch into ir, field decode, next-PC update.
// Optional halt-on-OP_HALT behaviour and the halted port are enabled by FETCH_HALT_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              dec_ready,
  input  logic              nia,
  output logic [3:0]        opcode,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [2:0]        rd,
  output logic [2:0]        func,
  output logic [5:0]        imm6,
  output logic [11:0]       jump_off,
`ifdef FETCH_HALT_EN
  output logic              halted,
`endif
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [1:0] REQ   = FS_REQ;
  localparam logic [1:0] ISSUE = FS_ISSUE;
  localparam logic [1:0] HALT  = FS_HALT;

  logic [1:0]         state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [ADDR_W-1:0]  pc_out_reg;
  logic [ADDR_W-1:0]  calc_pc;
  logic [INSTR_W-1:0] ir_reg;
  // Low for the cycle after a reset edge so no request is raised while in reset.
  logic               live_reg;
  logic               capture;

  assign capture = (state_reg == REQ) && live_reg && imem_ack;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
    .pc       (pc_reg),
    .nia      (nia),
    .jump_off (ir_reg[JOFF_MSB:0]),
    .next_pc  (calc_pc)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      REQ: begin
        if (capture) state_next = ISSUE;
      end
      ISSUE: begin
        if (dec_ready) begin
`ifdef FETCH_HALT_EN
          if (ir_reg[OPC_MSB:OPC_LSB] == OP_HALT) begin
            state_next = HALT;
          end else begin
            pc_next    = calc_pc;
            state_next = REQ;
          end
`else
          pc_next    = calc_pc;
          state_next = REQ;
`endif
        end
      end
      HALT:    state_next = HALT;
      default: state_next = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= REQ;
      pc_reg     <= RESET_PC;
      pc_out_reg <= RESET_PC;
      ir_reg     <= '0;
      live_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      live_reg  <= 1'b1;
      if (capture) begin
        ir_reg     <= imem_rdata;
        pc_out_reg <= pc_reg;
      end
    end
  end

  assign imem_req   = (state_reg == REQ) && live_reg;
  assign imem_addr  = pc_reg;
  assign inst_valid = (state_reg == ISSUE);
  assign pc_out     = pc_out_reg;

  assign opcode   = ir_reg[OPC_MSB:OPC_LSB];
  assign rs       = ir_reg[RS_MSB:RS_LSB];
  assign rt       = ir_reg[RT_MSB:RT_LSB];
  assign rd       = ir_reg[RD_MSB:RD_LSB];
  assign func     = ir_reg[FUNC_MSB:FUNC_LSB];
  assign imm6     = ir_reg[IMM6_MSB:0];
  assign jump_off = ir_reg[JOFF_MSB:0];

`ifdef FETCH_HALT_EN
  assign halted = (state_reg == HALT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch vectors push expected issue
// records; a negedge monitor compares each issued instruction. Honors FETCH_HALT_EN.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_ack, inst_valid, dec_ready, nia;
  logic [15:0] imem_addr, imem_rdata, pc_out;
  logic [3:0]  opcode;
  logic [2:0]  rs, rt, rd, func;
  logic [5:0]  imm6;
  logic [11:0] jump_off;

  logic        w_req, w_ack, w_valid, w_ready, w_nia;
  logic [15:0] w_addr, w_rdata, w_pc_out;
  logic [3:0]  w_opcode;
  logic [2:0]  w_rs, w_rt, w_rd, w_func;
  logic [5:0]  w_imm6;
  logic [11:0] w_jump_off;
`ifdef FETCH_HALT_EN
  logic        halted, w_halted;
`endif

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .dec_ready(dec_ready), .nia(nia), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .func(func), .imm6(imm6), .jump_off(jump_off),
`ifdef FETCH_HALT_EN
    .halted(halted),
`endif
    .pc_out(pc_out)
  );

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_valid(w_valid),
    .dec_ready(w_ready), .nia(w_nia), .opcode(w_opcode), .rs(w_rs), .rt(w_rt),
    .rd(w_rd), .func(w_func), .imm6(w_imm6), .jump_off(w_jump_off),
`ifdef FETCH_HALT_EN
    .halted(w_halted),
`endif
    .pc_out(w_pc_out)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every issuing cycle must show the front record; pop on acceptance.
  always @(negedge clk) begin
    if (rst_n && inst_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL issue_unexpected: got pc_out=%0h opcode=%0h expected no issue", pc_out, opcode);
      end else begin
        mon_e = sb_q[0];
        check("issue", 64'({pc_out, opcode, rs, rt, rd, func, imm6, jump_off, imem_req}),
              64'({mon_e.addr, mon_e.data[15:12], mon_e.data[11:9], mon_e.data[8:6],
                   mon_e.data[5:3], mon_e.data[2:0], mon_e.data[5:0], mon_e.data[11:0], 1'b0}));
        $display("issue pc=%04h ir=%04h ready=%0b", pc_out, mon_e.data, dec_ready);
        if (dec_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] addr, input logic [15:0] data, input int delay,
                       input logic nia_v, input int stall, output int waited);
    waited = 0;
    while (!imem_req && waited < 20) begin
      step();
      waited++;
    end
    if (!imem_req) begin
      n_cmp++;
      n_fail++;
      $display("FAIL req_timeout: got no imem_req expected request at %04h", addr);
      return;
    end
    check("fetch_addr", 64'(imem_addr), 64'(addr));
    for (int i = 0; i < delay; i++) begin
      check("wait_req_addr", 64'({imem_req, inst_valid, imem_addr}), 64'({1'b1, 1'b0, addr}));
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb_q.push_back('{addr, data});
    step();
    imem_ack   = 1'b0;
    imem_rdata = 16'hDEAD;
    for (int i = 0; i < stall; i++) step();
    dec_ready = 1'b1;
    nia       = nia_v;
    step();
    dec_ready = 1'b0;
    nia       = 1'b1;
    $display("fetch addr=%04h data=%04h delay=%0d stall=%0d nia=%0b", addr, data, delay, stall, nia_v);
  endtask

  int w;
  logic [15:0] seq_addr;

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; dec_ready = 1'b0; nia = 1'b1;
    w_ack = 1'b0; w_rdata = '0; w_ready = 1'b0; w_nia = 1'b1;
    step();
    step();
    check("reset_outputs", 64'({imem_req, inst_valid, pc_out, opcode, func, jump_off}), 64'(0));
    rst_n = 1'b1;

    // Back-to-back R-type fetches, one instruction per two cycles.
    fetch(16'h0000, 16'h0002, 0, 1'b1, 0, w);
    fetch(16'h0002, 16'h0002, 0, 1'b1, 0, w);
    check("throughput_wait", 64'(w), 64'(0));
    fetch(16'h0004, 16'h0002, 0, 1'b1, 0, w);
    check("throughput_wait", 64'(w), 64'(0));
    seq_addr = 16'h0006;
    for (int i = 0; i < 5; i++) begin
      fetch(seq_addr, 16'h0002, 0, 1'b1, 0, w);
      seq_addr = seq_addr + 16'h2;
    end

    // Jumps: -2 words from 0x10 -> 0x0E, then +5 words -> 0x1A.
    fetch(16'h0010, 16'h2FFE, 0, 1'b0, 0, w);
    fetch(16'h000E, 16'h2005, 0, 1'b0, 0, w);

    // Backpressure for 5 cycles, single PC advance afterwards.
    fetch(16'h001A, 16'h4A5B, 0, 1'b1, 5, w);

    // Memory wait of 3 cycles.
    fetch(16'h001C, 16'hB123, 3, 1'b1, 0, w);

    // Reset mid-request with an ack that must be discarded.
    check("pre_reset_req", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h001E}));
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
    step();
    check("reset_mid_req", 64'({imem_req, inst_valid, pc_out, opcode}), 64'(0));
    rst_n = 1'b1; imem_ack = 1'b0;
    fetch(16'h0000, 16'h0002, 0, 1'b1, 0, w);

    // Wrap-around on the RESET_PC=0xFFFE instance.
    step();
    check("wrap_first_req", 64'({w_req, w_addr}), 64'({1'b1, 16'hFFFE}));
    w_ack = 1'b1; w_rdata = 16'h0002;
    step();
    w_ack = 1'b0;
    check("wrap_issue", 64'({w_valid, w_pc_out, w_func}), 64'({1'b1, 16'hFFFE, 3'b010}));
    w_ready = 1'b1; w_nia = 1'b1;
    step();
    w_ready = 1'b0;
    check("wrap_next_req", 64'({w_req, w_addr}), 64'({1'b1, 16'h0000}));

    // Halt opcode: stops fetching when enabled, otherwise sequential.
    fetch(16'h0002, 16'hE000, 0, 1'b1, 0, w);
`ifdef FETCH_HALT_EN
    for (int i = 0; i < 4; i++) begin
      check("halted_state", 64'({halted, imem_req, inst_valid}), 64'(3'b100));
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("halt_reset", 64'({halted, imem_req}), 64'(0));
    fetch(16'h0000, 16'h0002, 0, 1'b1, 0, w);
`else
    fetch(16'h0004, 16'h0002, 0, 1'b1, 0, w);
    check("halt_op_seq_wait", 64'(w), 64'(0));
`endif

    step();
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
